// File: rtl/sb_pkg.sv
// sb_pkg: shared sizes and drain-state encoding for the store buffer
package sb_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 32;
  localparam int SB_DW = 32;
  localparam int SB_PW = $clog2(SB_DEPTH);
  localparam int SB_CW = SB_PW + 1;
  typedef enum logic {SB_IDLE = 1'b0, SB_REQ = 1'b1} sb_state_e;
endpackage

// File: rtl/sb_if.sv
// sb_if: store, load-lookup and memory-drain signals of the store buffer
interface sb_if import sb_pkg::*; #(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
);
  logic          i_sb_wr;
  logic [AW-1:0] i_sb_addr;
  logic [DW-1:0] i_sb_data;
  logic          o_sb_full;
  logic          o_sb_empty;
  logic          i_ld_valid;
  logic [AW-1:0] i_ld_addr;
  logic          o_ld_hit;
  logic [DW-1:0] o_ld_data;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          i_mem_ack;
  modport master (
    output i_sb_wr, i_sb_addr, i_sb_data, i_ld_valid, i_ld_addr, i_mem_ack,
    input  o_sb_full, o_sb_empty, o_ld_hit, o_ld_data, o_mem_req, o_mem_addr, o_mem_data
  );
  modport slave (
    input  i_sb_wr, i_sb_addr, i_sb_data, i_ld_valid, i_ld_addr, i_mem_ack,
    output o_sb_full, o_sb_empty, o_ld_hit, o_ld_data, o_mem_req, o_mem_addr, o_mem_data
  );
endinterface

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: address compare over all entries, youngest valid match wins
module sb_fwd_match import sb_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] vld,
  input  logic [AW-1:0]    addr [DEPTH],
  input  logic [DW-1:0]    data [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  output logic             hit,
  output logic [DW-1:0]    ld_data
);
  logic          any;
  logic [DW-1:0] sel;
  logic [PW-1:0] idx;
  // walk oldest to youngest from head so the last match seen is the youngest
  always_comb begin
    any = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (vld[idx] && addr[idx] == ld_addr) begin
        any = 1'b1;
        sel = data[idx];
      end
    end
  end
  assign hit = ld_valid & any;
  assign ld_data = hit ? sel : '0;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order store queue with memory drain and load forwarding
module store_buffer import sb_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input logic clk,
  input logic rst,
  sb_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [PW:0]      count_q, count_nx;
  sb_state_e        state_q, state_nx;
  logic             push, pop;
  assign bus.o_sb_full = count_q == (PW+1)'(DEPTH);
  assign bus.o_sb_empty = count_q == '0;
  assign push = bus.i_sb_wr & ~bus.o_sb_full;
  assign pop = (state_q == SB_REQ) & bus.i_mem_ack;
  assign count_nx = count_q + (PW+1)'(push) - (PW+1)'(pop);
  assign bus.o_mem_req = state_q == SB_REQ;
  assign bus.o_mem_addr = bus.o_mem_req ? addr_q[head_q] : '0;
  assign bus.o_mem_data = bus.o_mem_req ? data_q[head_q] : '0;
  // entry payload needs no reset; valid bits gate every use of it
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.i_sb_addr;
      data_q[tail_q] <= bus.i_sb_data;
    end
  end
  // pointers, occupancy and valid bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      vld_q <= '0;
    end else begin
      tail_q <= tail_q + PW'(push);
      head_q <= head_q + PW'(pop);
      count_q <= count_nx;
      vld_q <= (vld_q | (DEPTH'(push) << tail_q)) & ~(DEPTH'(pop) << head_q);
    end
  end
  // drain state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SB_IDLE;
    else state_q <= state_nx;
  end
  // request whenever anything will be left after this cycle's push/pop
  always_comb begin
    state_nx = (count_nx != '0) ? SB_REQ : SB_IDLE;
  end
  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd (
    .vld(vld_q),
    .addr(addr_q),
    .data(data_q),
    .head(head_q),
    .ld_valid(bus.i_ld_valid),
    .ld_addr(bus.i_ld_addr),
    .hit(bus.o_ld_hit),
    .ld_data(bus.o_ld_data)
  );
endmodule
